lsu_load_unit: RTL

- Read side of the miniRISC data-memory path: accepts a load request from the execute stage and issues a single-cycle read to the synchronous data BRAM.
- Waits a fixed BRAM read latency, then extracts the addressed byte, half or word and sign- or zero-extends it to 32 bits.
- Returns a one-cycle response to writeback and stalls the pipeline while busy.
- Pairs with the existing store path, which is the writer to the same BRAM.

---
 rtl/miniRISC_pkg.sv | 16 +
 rtl/load_align.sv | 45 ++++
 rtl/lsu_load_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/miniRISC_pkg.sv
// Shared miniRISC data-path definitions: load/store size encodings and the load-unit FSM states.
package miniRISC_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational byte/half/word lane extraction with sign/zero extension, plus misalign detection.
// Zero latency, no state; the store path reuses misalign_o for its own alignment check.
module load_align
  import miniRISC_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o,
  output logic        misalign_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word_i[7:0];
    case (off_i)
      2'd1:    byte_lane = word_i[15:8];
      2'd2:    byte_lane = word_i[23:16];
      2'd3:    byte_lane = word_i[31:24];
      default: byte_lane = word_i[7:0];
    endcase
    half_lane = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    result_o   = '0;
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: result_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
      SZ_HALF: begin
        result_o   = {{16{signed_i & half_lane[15]}}, half_lane};
        misalign_o = off_i[0];
      end
      SZ_WORD: begin
        result_o   = word_i;
        misalign_o = (off_i != 2'd0);
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_load_unit.sv
// Load path: one BRAM read per request, response RD_LATENCY+1 cycles after the read enable (error: next cycle).
// One request in flight; req_ready only in IDLE, stall flags a waiting request; responses cannot be backpressured.
module lsu_load_unit
  import miniRISC_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              stall,
  output logic              mem_en,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

  ld_state_e         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              err_q, err_d;
  logic [ADDR_W-3:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              idle;
  logic [1:0]        al_off, al_size;
  logic              al_sgn;
  logic [DATA_W-1:0] al_result;
  logic              al_misalign;

  assign idle = (state_q == IDLE);

  // In IDLE the aligner checks the incoming request; afterwards it extracts from the latched fields.
  assign al_off  = idle ? req_addr[1:0] : off_q;
  assign al_size = idle ? req_size      : size_q;
  assign al_sgn  = idle ? req_signed    : sgn_q;

  load_align u_align (
    .word_i     (mem_rdata),
    .off_i      (al_off),
    .size_i     (al_size),
    .signed_i   (al_sgn),
    .result_o   (al_result),
    .misalign_o (al_misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    err_d   = err_q;
    maddr_d = maddr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d  = req_addr[1:0];
          size_d = req_size;
          sgn_d  = req_signed;
          if (al_misalign) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            maddr_d = req_addr[ADDR_W-1:2];
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = al_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      maddr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      maddr_q <= maddr_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready  = idle;
  assign stall      = req_valid & ~idle;
  assign mem_en     = (state_q == ISSUE);
  assign mem_addr   = maddr_q;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = rdata_q;
  assign resp_err   = err_q;

endmodule
